// File: rtl/plca_segment_collision_monitor_if.sv
// Bundles the segment activity inputs and the collision monitor results.
// master drives tx_activity/stats_clear; slave is the monitor.
interface plca_segment_collision_monitor_if #(
    parameter int NODES = 16,
    parameter int CNT_W = 16
);
    logic [NODES-1:0] tx_activity;
    logic             stats_clear;
    logic             collision;
    logic [4:0]       active_count;
    logic [1:0]       seg_state;
    logic [CNT_W-1:0] col_event_count;
    logic [CNT_W-1:0] col_cycles_max;
    logic [NODES-1:0] col_nodes;

    modport master (
        output tx_activity, stats_clear,
        input  collision, active_count, seg_state,
               col_event_count, col_cycles_max, col_nodes
    );

    modport slave (
        input  tx_activity, stats_clear,
        output collision, active_count, seg_state,
               col_event_count, col_cycles_max, col_nodes
    );
endinterface

// File: rtl/plca_segment_collision_monitor.sv
// Registered collision detector for the shared 10BASE-T1S segment, with hold extension.
// Define PLCA_COL_STATS_EN to build the event statistics; otherwise they read 0.
module plca_segment_collision_monitor #(
    parameter int NODES    = 16,
    parameter int COL_HOLD = 4,
    parameter int CNT_W    = 16
) (
    input logic clk,
    input logic reset_n,
    plca_segment_collision_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_COL    = 2'd2,
        S_HOLD   = 2'd3
    } seg_state_e;

    localparam logic [7:0] HOLD_INIT = 8'(COL_HOLD);

    seg_state_e state, state_nxt;
    logic [4:0] n;
    logic [4:0] active_q;
    logic [7:0] hold_cnt;
    logic       multi;
    logic       evt_start;
    logic       reenter;
    logic       hold_load;

    // Full-width population count so 16 active nodes never wraps to 0.
    always_comb begin
        n = '0;
        for (int i = 0; i < NODES; i++) n = n + 5'(bus.tx_activity[i]);
    end

    assign multi = (n > 5'd1);

    always_comb begin
        state_nxt = state;
        evt_start = 1'b0;
        reenter   = 1'b0;
        hold_load = 1'b0;
        case (state)
            S_IDLE, S_SINGLE: begin
                if (multi) begin
                    state_nxt = S_COL;
                    evt_start = 1'b1;
                end else begin
                    state_nxt = (n == 5'd0) ? S_IDLE : S_SINGLE;
                end
            end
            S_COL: begin
                if (multi)                state_nxt = S_COL;
                else if (COL_HOLD == 0)   state_nxt = (n == 5'd0) ? S_IDLE : S_SINGLE;
                else begin
                    state_nxt = S_HOLD;
                    hold_load = 1'b1;
                end
            end
            S_HOLD: begin
                if (multi) begin
                    state_nxt = S_COL;
                    reenter   = 1'b1;
                end else if (hold_cnt == 8'd1) begin
                    state_nxt = (n == 5'd0) ? S_IDLE : S_SINGLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            active_q <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            active_q <= n;
            if (hold_load)                               hold_cnt <= HOLD_INIT;
            else if (state == S_HOLD && hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
        end
    end

    assign bus.collision    = (state == S_COL) || (state == S_HOLD);
    assign bus.active_count = active_q;
    assign bus.seg_state    = state;

`ifdef PLCA_COL_STATS_EN
    logic [CNT_W-1:0] run_cnt, run_nxt;
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] max_q;
    logic [NODES-1:0] nodes_q;
    logic             in_overlap;

    assign in_overlap = (state == S_COL) && multi;

    always_comb begin
        run_nxt = run_cnt;
        if (evt_start || reenter)  run_nxt = CNT_W'(1);
        else if (in_overlap)       run_nxt = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
    end

    // An event start beats a coincident clear; clear beats ongoing accumulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt <= '0;
            evt_cnt <= '0;
            max_q   <= '0;
            nodes_q <= '0;
        end else begin
            run_cnt <= run_nxt;
            if (evt_start) begin
                evt_cnt <= bus.stats_clear ? CNT_W'(1)
                         : ((evt_cnt == '1) ? evt_cnt : evt_cnt + 1'b1);
                nodes_q <= bus.tx_activity;
                max_q   <= (bus.stats_clear || run_nxt > max_q) ? run_nxt : max_q;
            end else if (bus.stats_clear) begin
                evt_cnt <= '0;
                max_q   <= '0;
                nodes_q <= '0;
            end else if (in_overlap || reenter) begin
                nodes_q <= nodes_q | bus.tx_activity;
                max_q   <= (run_nxt > max_q) ? run_nxt : max_q;
            end
        end
    end

    assign bus.col_event_count = evt_cnt;
    assign bus.col_cycles_max  = max_q;
    assign bus.col_nodes       = nodes_q;
`else
    logic unused_stats_clear;
    assign unused_stats_clear  = bus.stats_clear;
    assign bus.col_event_count = '0;
    assign bus.col_cycles_max  = '0;
    assign bus.col_nodes       = '0;
`endif

endmodule

// File: tb/tb_plca_segment_collision_monitor.sv
// Directed bench for the segment collision monitor; statistics expectations follow
// whether PLCA_COL_STATS_EN is defined.
module tb_plca_segment_collision_monitor;

`ifdef PLCA_COL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    plca_segment_collision_monitor_if #(.NODES(16), .CNT_W(16)) bus ();

    plca_segment_collision_monitor #(.NODES(16), .COL_HOLD(4), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Statistics read 0 when the feature is compiled out.
    function automatic logic [31:0] st(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_core(input string tag, input logic col, input logic [4:0] cnt,
                            input logic [1:0] s);
        chk({tag, ".collision"}, 32'(bus.collision), 32'(col));
        chk({tag, ".active"},    32'(bus.active_count), 32'(cnt));
        chk({tag, ".state"},     32'(bus.seg_state), 32'(s));
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] ev, input logic [31:0] mx,
                             input logic [31:0] nd);
        chk({tag, ".events"}, 32'(bus.col_event_count), st(ev));
        chk({tag, ".max"},    32'(bus.col_cycles_max),  st(mx));
        chk({tag, ".nodes"},  32'(bus.col_nodes),       st(nd));
    endtask

    // Drain a 4-cycle hold with tx=0 and confirm the segment returns to IDLE.
    task automatic drain_hold(input string tag);
        bus.tx_activity = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_core({tag, ".hold"}, 1'b1, 5'd0, 2'd3);
        end
        step();
        chk_core({tag, ".idle"}, 1'b0, 5'd0, 2'd0);
    endtask

    initial begin
        bus.tx_activity = '0;
        bus.stats_clear = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        chk_core("reset", 1'b0, 5'd0, 2'd0);
        chk_stats("reset", 0, 0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) step();
        chk_core("idle10", 1'b0, 5'd0, 2'd0);
        chk_stats("idle10", 0, 0, 0);

        // Single talker never collides.
        bus.tx_activity = 16'h0008;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_core("single", 1'b0, 5'd1, 2'd1);
        end
        chk_stats("single", 0, 0, 0);
        bus.tx_activity = 16'h0000;
        step();
        chk_core("single_end", 1'b0, 5'd0, 2'd0);

        // Nodes 2 and 5 overlap 6 cycles: 6 COL + 4 HOLD = 10 cycles of collision.
        bus.tx_activity = 16'h0024;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_core("ov6", 1'b1, 5'd2, 2'd2);
        end
        chk_stats("ov6", 1, 6, 16'h0024);
        drain_hold("ov6");

        // All 16 nodes: popcount must read 16.
        bus.tx_activity = 16'hFFFF;
        step();
        chk_core("all16", 1'b1, 5'd16, 2'd2);
        chk_stats("all16", 2, 6, 16'hFFFF);
        step();
        bus.tx_activity = 16'h0000;
        step();
        step();
        chk_core("hold2", 1'b1, 5'd0, 2'd3);
        // Re-entry 2 cycles into HOLD is the same event; run restarts at 1.
        bus.tx_activity = 16'h0003;
        step();
        chk_core("reenter", 1'b1, 5'd2, 2'd2);
        chk_stats("reenter", 2, 6, 16'hFFFF);
        for (int i = 0; i < 6; i++) step();
        chk_core("reenter7", 1'b1, 5'd2, 2'd2);
        chk_stats("reenter7", 2, 7, 16'hFFFF);
        drain_hold("reenter");

        // stats_clear after 3 cycles of a 5-cycle overlap.
        bus.tx_activity = 16'h0011;
        repeat (3) step();
        chk_stats("pre_clr", 3, 7, 16'h0011);
        bus.stats_clear = 1'b1;
        step();
        bus.stats_clear = 1'b0;
        chk_core("clr", 1'b1, 5'd2, 2'd2);
        chk_stats("clr", 0, 0, 0);
        step();
        chk_core("post_clr", 1'b1, 5'd2, 2'd2);
        chk_stats("post_clr", 0, 5, 16'h0011);
        drain_hold("clr");

        // Clear coinciding with an event start: the start wins.
        bus.tx_activity = 16'h0006;
        bus.stats_clear = 1'b1;
        step();
        bus.stats_clear = 1'b0;
        chk_core("clr_start", 1'b1, 5'd2, 2'd2);
        chk_stats("clr_start", 1, 1, 16'h0006);
        drain_hold("clr_start");

        // Reset inside COL clears everything asynchronously.
        bus.tx_activity = 16'h0300;
        step();
        step();
        chk_stats("pre_rst", 2, 2, 16'h0300);
        reset_n = 1'b0;
        #1;
        chk_core("async_rst", 1'b0, 5'd0, 2'd0);
        chk_stats("async_rst", 0, 0, 0);
        step();
        step();
        chk_core("rst_hold", 1'b0, 5'd0, 2'd0);
        reset_n = 1'b1;
        step();
        chk_core("rst_rel", 1'b1, 5'd2, 2'd2);
        chk_stats("rst_rel", 1, 1, 16'h0300);
        bus.tx_activity = 16'h0000;
        step();
        chk_core("rst_rel_hold", 1'b1, 5'd0, 2'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
